// File: rtl/rr_switch_arbiter1.sv
// Round-robin switch allocator for router output port 1: five inputs compete,
// the winner is held head-to-tail (wormhole) and a transfer strobe pops its buffer.
module rr_switch_arbiter1 #(
  parameter int LOCK_EN = 1,
  parameter int NUM_IN  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] tail,
  input  logic       out_ready,
  output logic       g10,
  output logic       g11,
  output logic       g12,
  output logic       g13,
  output logic       g14,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic       xfer
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [2:0] owner_r, owner_s;
  logic [4:0] grant_r, grant_s;
  logic [3:0] pick_s;
  logic       release_s;

  // Returns {found, index} of the first requester scanning p, p+1, ... modulo 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [3:0] sum;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 4; k >= 0; k--) begin
      sum = {1'b0, p} + 4'(k);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(req, ptr_r);
  assign grant_valid = |grant_r;
  assign grant_id    = owner_r;
  assign xfer        = grant_valid & req[owner_r] & out_ready;
  // Without wormhole locking every transfer is a release point.
  assign release_s   = xfer & ((LOCK_EN == 0) | tail[owner_r]);

  assign g10 = grant_r[0];
  assign g11 = grant_r[1];
  assign g12 = grant_r[2];
  assign g13 = grant_r[3];
  assign g14 = grant_r[4];

  // Next-state: grant the first requester in IDLE, release on the packet's last transfer.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    grant_s = grant_r;
    case (state_r)
      IDLE: begin
        if (pick_s[3]) begin
          state_s = LOCKED;
          owner_s = pick_s[2:0];
          grant_s = 5'b00001 << pick_s[2:0];
        end else begin
          grant_s = 5'b00000;
          owner_s = 3'd0;
        end
      end
      LOCKED: begin
        if (release_s) begin
          state_s = IDLE;
          grant_s = 5'b00000;
          owner_s = 3'd0;
          ptr_s   = (owner_r == 3'd4) ? 3'd0 : owner_r + 3'd1;
        end else begin
          grant_s = grant_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 5'b00000;
        owner_s = 3'd0;
        ptr_s   = 3'd0;
      end
    endcase
  end

  // State, pointer, owner and grant registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      owner_r <= 3'd0;
      grant_r <= 5'b00000;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      grant_r <= grant_s;
    end
  end

endmodule

// File: doc/rr_switch_arbiter1.md
Name: rr_switch_arbiter1

Overview:
- Round-robin switch allocator for router output port 1.
- Arbitrates among the five input ports (0..4) requesting output 1.
- Holds the winner for a whole wormhole packet, head to tail.
- Drives one-hot grants g10..g14 directly into the output-1 select encoder and crossbar column, plus a per-cycle transfer strobe that pops the winning input buffer.

Parameters:
- LOCK_EN, 1: 1 = grant held from head to tail flit (wormhole); 0 = re-arbitrate after every flit transfer.
- NUM_IN, 5: number of input ports. Fixed at 5; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset, sampled on rising clk.
- req  input  5  req[i]=1: input buffer i has a flit at its head routed to output 1.
- tail  input  5  tail[i]=1: the head flit of input buffer i is a tail flit. Valid only when req[i]=1.
- out_ready  input  1  downstream (output-1 link/buffer) can accept a flit this cycle.
- g10  output  1  grant to input 0.
- g11  output  1  grant to input 1.
- g12  output  1  grant to input 2.
- g13  output  1  grant to input 3.
- g14  output  1  grant to input 4.
- grant_valid  output  1  OR of g10..g14.
- grant_id  output  3  encoded owner index, 0..4. Holds 0 when grant_valid=0.
- xfer  output  1  a flit moves this cycle. Combinational: grant_valid & req[grant_id] & out_ready.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, ptr=0, g10..g14=0, grant_valid=0, grant_id=0.
  - xfer is therefore 0.
  - Reset mid-packet drops the grant with no tail handshake.
- Registered state: state in {IDLE, LOCKED}; ptr[2:0] in 0..4 (highest-priority input); owner[2:0].
- All grant outputs are registered. At most one of g10..g14 is ever 1.
- IDLE:
  - If req==0, remain IDLE with grants 0.
  - Otherwise choose the first i with req[i]=1, scanning ptr, ptr+1, … modulo 5.
  - Next edge: owner=i, the matching g1i=1, state=LOCKED.
  - Latency: request in cycle n gives grant visible in cycle n+1.
  - tail and out_ready are ignored in IDLE.
- LOCKED:
  - Grant held constant.
  - A transfer occurs in any cycle with xfer=1.
  - LOCK_EN=1:
    - Non-tail transfer: stay LOCKED.
    - Transfer with tail[owner]=1: next edge grants=0, ptr=(owner+1) mod 5, state=IDLE.
  - LOCK_EN=0: every transfer releases as above, regardless of tail.
  - req[owner]=0 while LOCKED (buffer bubble mid-packet): xfer=0 and the grant is held. No release, no timeout.
  - out_ready=0: xfer=0, grant held indefinitely.
- Release to next grant:
  - The cycle after a releasing transfer is IDLE with grants 0 (one bubble cycle).
  - A new grant appears the following cycle.
  - Minimum gap between two packets is one cycle.
- Fairness:
  - ptr advances only on release.
  - A continuously requesting input waits at most 4 packets.
- Single-flit packet (head is also tail, tail=1 on the first transfer): released after one transfer.
- Wrap-around: owner=4 releases to ptr=0.
- Requests from non-owners while LOCKED are ignored. No preemption.

Test Plan:
- Reset, then req=5'b00000 for 5 cycles → g10..g14=0, grant_valid=0, xfer=0 every cycle.
- After reset, req=5'b10110, out_ready=1, each packet 3 flits (tail on 3rd xfer) → grant order input1, input2, input4:
  - input1 grant at cycle 1.
  - xfer in cycles 1,2,3; IDLE at cycle 4.
  - g12 at cycle 5; g14 follows the same pattern.
- Owner 2 mid-packet with out_ready=0 for 4 cycles, then req[2]=0 for 2 cycles → g12 stays 1 and xfer=0 throughout; transfer resumes when both return.
- ptr=4 via prior release of input 3, req=5'b11111, single-flit packets (tail=1 always) → grants rotate 4,0,1,2,3,4, one bubble between each.
- LOCK_EN=0, req=5'b00011, tail=0 → grants alternate 0,1,0,1 per transfer.
- rst=0 asserted while owner 3 LOCKED mid-packet → next edge all grants 0, ptr=0; with req=5'b01001, input 0 is granted first after rst=1.
